// File: rtl/video_mode_detector_pkg.sv
// Shared types and nominal timing constants for the Dreamcast video mode detector.
package video_mode_detector_pkg;

  typedef enum logic [1:0] {
    UNKNOWN   = 2'd0,
    VGA_480P  = 2'd1,
    NTSC_240P = 2'd2,
    NTSC_480I = 2'd3
  } VideoMode;

  typedef enum logic {
    StTrack  = 1'b0,
    StLocked = 1'b1
  } DebounceState;

  localparam int unsigned H_480P    = 1716;
  localparam int unsigned H_15K     = 3432;
  localparam int unsigned V_480P    = 525;
  localparam int unsigned V_15K_MIN = 261;
  localparam int unsigned V_15K_MAX = 264;

  function automatic logic in_range(input logic [11:0] val, input logic [11:0] lo,
                                    input logic [11:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers an active-low sync input once and flags its falling edge for one cycle.
module sync_edge_detect (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_sync_n,
  output logic o_fall
);

  logic r_cur;
  logic r_prev;

  // Both flops clear to 0 so a sync held low across reset is not seen as an edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cur  <= i_sync_n;
      r_prev <= r_cur;
    end
  end

  assign o_fall = r_prev & ~r_cur;

endmodule

// File: rtl/video_mode_detector.sv
// Measures line/field timing, classifies 480p/240p/480i and debounces the result
// into a stable mode and line-doubler indication.
module video_mode_detector
  import video_mode_detector_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = 4,
  parameter int unsigned H_TOL         = 8,
  parameter int unsigned TIMEOUT       = 4194304,
  parameter int unsigned H_REF_480P    = H_480P,
  parameter int unsigned H_REF_15K     = H_15K,
  parameter int unsigned V_REF_480P    = V_480P,
  parameter int unsigned V_REF_15K_MIN = V_15K_MIN,
  parameter int unsigned V_REF_15K_MAX = V_15K_MAX
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_hsync_n,
  input  logic        i_vsync_n,
  output logic [11:0] o_h_total,
  output logic [10:0] o_v_total,
  output logic        o_interlaced,
  output logic [1:0]  o_video_mode,
  output logic        o_mode_valid,
  output logic        o_mode_changed,
  output logic        o_line_doubler
);

  localparam logic [11:0] H480Lo = 12'(H_REF_480P - H_TOL);
  localparam logic [11:0] H480Hi = 12'(H_REF_480P + H_TOL);
  localparam logic [11:0] H15kLo = 12'(H_REF_15K - H_TOL);
  localparam logic [11:0] H15kHi = 12'(H_REF_15K + H_TOL);
  localparam logic [11:0] V480Lo = 12'(V_REF_480P - 1);
  localparam logic [11:0] V480Hi = 12'(V_REF_480P + 1);
  localparam logic [11:0] V15kLo = 12'(V_REF_15K_MIN);
  localparam logic [11:0] V15kHi = 12'(V_REF_15K_MAX);
  localparam logic [2:0]  StableCnt = 3'(STABLE_FRAMES);
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdMax  = WdW'(TIMEOUT);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  logic w_hs_fall;
  logic w_vs_fall;

  sync_edge_detect u_hsync_edge (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_sync_n (i_hsync_n),
    .o_fall   (w_hs_fall)
  );

  sync_edge_detect u_vsync_edge (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_sync_n (i_vsync_n),
    .o_fall   (w_vs_fall)
  );

  logic [11:0] r_h_cnt;
  logic [11:0] r_h_total;
  logic [10:0] r_line_cnt;
  logic [10:0] r_v_total;
  logic        r_half_prev;
  logic        r_last_diff;
  logic        r_interlaced;
  logic        r_seen_vs;
  logic        r_full_field;
  logic        r_eval;
  logic [WdW-1:0] r_wd;

  logic [11:0] w_h_cnt_inc;
  logic [10:0] w_line_inc;
  logic [11:0] w_q1;
  logic [11:0] w_q3;
  logic        w_half;
  logic        w_diff;
  logic        w_wd_fire;

  assign w_h_cnt_inc = (r_h_cnt == 12'hfff) ? r_h_cnt : r_h_cnt + 12'd1;
  assign w_line_inc  = (r_line_cnt == 11'h7ff) ? r_line_cnt : r_line_cnt + 11'd1;
  assign w_q1        = {2'b00, r_h_total[11:2]};
  assign w_q3        = 12'(({2'b00, r_h_total} + {1'b0, r_h_total, 1'b0}) >> 2);
  assign w_half      = (r_h_cnt >= w_q1) && (r_h_cnt < w_q3);
  assign w_diff      = w_half ^ r_half_prev;
  assign w_wd_fire   = (r_wd == WdLast) && !w_vs_fall;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_h_cnt      <= '0;
      r_h_total    <= '0;
      r_line_cnt   <= '0;
      r_v_total    <= '0;
      r_half_prev  <= 1'b0;
      r_last_diff  <= 1'b0;
      r_interlaced <= 1'b0;
      r_seen_vs    <= 1'b0;
      r_full_field <= 1'b0;
      r_eval       <= 1'b0;
      r_wd         <= '0;
    end else begin
      r_h_cnt <= w_hs_fall ? 12'd0 : w_h_cnt_inc;
      if (w_hs_fall) r_h_total <= w_h_cnt_inc;
      // A coincident hsync belongs to the field being closed.
      if (w_vs_fall) begin
        r_line_cnt <= '0;
        r_v_total  <= w_hs_fall ? w_line_inc : r_line_cnt;
      end else if (w_hs_fall) begin
        r_line_cnt <= w_line_inc;
      end
      if (w_vs_fall) begin
        r_half_prev <= w_half;
        r_last_diff <= w_diff;
        if (w_diff && r_last_diff) r_interlaced <= 1'b1;
        else if (!w_diff && !r_last_diff) r_interlaced <= 1'b0;
        r_seen_vs    <= 1'b1;
        r_full_field <= r_seen_vs;
      end
      r_eval <= w_vs_fall;
      if (w_vs_fall) r_wd <= '0;
      else if (r_wd != WdMax) r_wd <= r_wd + WdW'(1);
    end
  end

  VideoMode w_cand;

  // The field ending at the first vsync after reset is partial and never qualifies.
  always_comb begin
    w_cand = UNKNOWN;
    if (r_full_field) begin
      if (in_range(r_h_total, H480Lo, H480Hi) && in_range({1'b0, r_v_total}, V480Lo, V480Hi)) begin
        w_cand = VGA_480P;
      end else if (in_range(r_h_total, H15kLo, H15kHi) &&
                   in_range({1'b0, r_v_total}, V15kLo, V15kHi)) begin
        w_cand = r_interlaced ? NTSC_480I : NTSC_240P;
      end
    end
  end

  DebounceState r_state;
  DebounceState w_state_nxt;
  VideoMode     r_video_mode;
  VideoMode     w_mode_nxt;
  VideoMode     r_prev_cand;
  VideoMode     w_prev_cand_nxt;
  logic [2:0]   r_stable_cnt;
  logic [2:0]   w_stable_nxt;
  logic         r_mode_changed;
  logic         w_changed_nxt;
  logic         r_mode_valid;
  logic         r_line_doubler;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= StTrack;
      r_video_mode   <= UNKNOWN;
      r_prev_cand    <= UNKNOWN;
      r_stable_cnt   <= '0;
      r_mode_changed <= 1'b0;
      r_mode_valid   <= 1'b0;
      r_line_doubler <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_video_mode   <= w_mode_nxt;
      r_prev_cand    <= w_prev_cand_nxt;
      r_stable_cnt   <= w_stable_nxt;
      r_mode_changed <= w_changed_nxt;
      r_mode_valid   <= (r_video_mode != UNKNOWN);
      r_line_doubler <= (r_video_mode == NTSC_240P) || (r_video_mode == NTSC_480I);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mode_nxt      = r_video_mode;
    w_prev_cand_nxt = r_prev_cand;
    w_stable_nxt    = r_stable_cnt;
    w_changed_nxt   = 1'b0;
    if (w_wd_fire) begin
      w_mode_nxt    = UNKNOWN;
      w_stable_nxt  = '0;
      w_changed_nxt = (r_video_mode != UNKNOWN);
      w_state_nxt   = StTrack;
    end else if (r_eval) begin
      w_prev_cand_nxt = w_cand;
      if (w_cand == r_prev_cand) begin
        w_stable_nxt = (r_stable_cnt == 3'd7) ? 3'd7 : r_stable_cnt + 3'd1;
      end else begin
        w_stable_nxt = 3'd1;
      end
      // Once locked, an odd frame restarts the count but cannot reach the threshold alone.
      if ((w_stable_nxt >= StableCnt) && (w_cand != r_video_mode)) begin
        w_mode_nxt    = w_cand;
        w_changed_nxt = 1'b1;
        w_state_nxt   = (w_cand == UNKNOWN) ? StTrack : StLocked;
      end
    end
  end

  assign o_h_total      = r_h_total;
  assign o_v_total      = r_v_total;
  assign o_interlaced   = r_interlaced;
  assign o_video_mode   = r_video_mode;
  assign o_mode_valid   = r_mode_valid;
  assign o_mode_changed = r_mode_changed;
  assign o_line_doubler = r_line_doubler;

endmodule

// File: tb/tb_video_mode_detector.sv
// Directed bench for video_mode_detector using scaled line/field timings.
module tb_video_mode_detector;

  logic        clk;
  logic        i_reset;
  logic        i_hsync_n;
  logic        i_vsync_n;
  logic [11:0] o_h_total;
  logic [10:0] o_v_total;
  logic        o_interlaced;
  logic [1:0]  o_video_mode;
  logic        o_mode_valid;
  logic        o_mode_changed;
  logic        o_line_doubler;

  int n_tests;
  int n_fail;
  int n_pulses;

  // 480p: 48 clk x 20..22 lines, 15 kHz: 96 clk x 9..12 lines, tolerance 8.
  video_mode_detector #(
    .STABLE_FRAMES (4),
    .H_TOL         (8),
    .TIMEOUT       (6000),
    .H_REF_480P    (48),
    .H_REF_15K     (96),
    .V_REF_480P    (21),
    .V_REF_15K_MIN (9),
    .V_REF_15K_MAX (12)
  ) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_hsync_n      (i_hsync_n),
    .i_vsync_n      (i_vsync_n),
    .o_h_total      (o_h_total),
    .o_v_total      (o_v_total),
    .o_interlaced   (o_interlaced),
    .o_video_mode   (o_video_mode),
    .o_mode_valid   (o_mode_valid),
    .o_mode_changed (o_mode_changed),
    .o_line_doubler (o_line_doubler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial n_pulses = 0;
  always @(negedge clk) if (o_mode_changed === 1'b1) n_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_h_total"}, o_h_total, 0);
    check_eq({tag, "_v_total"}, o_v_total, 0);
    check_eq({tag, "_interlaced"}, o_interlaced, 0);
    check_eq({tag, "_mode"}, o_video_mode, 0);
    check_eq({tag, "_valid"}, o_mode_valid, 0);
    check_eq({tag, "_changed"}, o_mode_changed, 0);
    check_eq({tag, "_doubler"}, o_line_doubler, 0);
  endtask

  // vs_at < 0 means no vsync in this line; otherwise vsync falls at that clock.
  task automatic drive_line(input int clks, input int vs_at);
    for (int c = 0; c < clks; c++) begin
      i_hsync_n = (c < 4) ? 1'b0 : 1'b1;
      i_vsync_n = (vs_at >= 0 && c >= vs_at && c < vs_at + 4) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_field(input int lines, input int clks, input int vs_at);
    drive_line(clks, vs_at);
    for (int l = 1; l < lines; l++) drive_line(clks, -1);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    i_reset   = 1'b1;
    i_hsync_n = 1'b1;
    i_vsync_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    i_reset = 1'b0;

    // 480p: first vsync closes a partial field, lock needs five vsync edges.
    repeat (4) drive_field(21, 48, 0);
    check_eq("480p_prelock_mode", o_video_mode, 0);
    repeat (2) drive_field(21, 48, 0);
    check_eq("480p_mode", o_video_mode, 1);
    check_eq("480p_pulses", n_pulses, 1);
    check_eq("480p_valid", o_mode_valid, 1);
    check_eq("480p_doubler", o_line_doubler, 0);
    check_eq("480p_h_total", o_h_total, 48);
    check_eq("480p_v_total", o_v_total, 21);
    check_eq("480p_interlaced", o_interlaced, 0);

    // Tolerance edge: +8 still 480p, +9 drops to UNKNOWN.
    repeat (5) drive_field(21, 56, 0);
    check_eq("tol8_mode", o_video_mode, 1);
    check_eq("tol8_h_total", o_h_total, 56);
    check_eq("tol8_pulses", n_pulses, 1);
    repeat (6) drive_field(21, 57, 0);
    check_eq("tol9_mode", o_video_mode, 0);
    check_eq("tol9_valid", o_mode_valid, 0);
    check_eq("tol9_pulses", n_pulses, 2);
    check_eq("tol9_h_total", o_h_total, 57);

    repeat (5) drive_field(21, 48, 0);
    check_eq("relock_mode", o_video_mode, 1);
    check_eq("relock_pulses", n_pulses, 3);

    // One 40-line frame while locked.
    drive_field(40, 48, 0);
    drive_field(21, 48, 0);
    check_eq("glitch_v_total", o_v_total, 40);
    drive_field(21, 48, 0);
    check_eq("glitch_mode", o_video_mode, 1);
    check_eq("glitch_pulses", n_pulses, 3);

    // Over-long last line saturates the line length.
    drive_line(48, 0);
    repeat (19) drive_line(48, -1);
    drive_line(4200, -1);
    drive_line(96, 0);
    check_eq("sat_h_total", o_h_total, 4095);
    check_eq("sat_v_total", o_v_total, 21);
    check_eq("sat_mode", o_video_mode, 1);

    // 240p: remainder of the first field plus four more.
    repeat (10) drive_line(96, -1);
    repeat (4) drive_field(11, 96, 0);
    check_eq("240p_mode", o_video_mode, 2);
    check_eq("240p_pulses", n_pulses, 4);
    check_eq("240p_interlaced", o_interlaced, 0);
    check_eq("240p_doubler", o_line_doubler, 1);
    check_eq("240p_h_total", o_h_total, 96);
    check_eq("240p_v_total", o_v_total, 11);

    // 480i: alternate mid-line and aligned vsync, 11/10 lines.
    drive_field(11, 96, 48);
    check_eq("480i_one_diff_interlaced", o_interlaced, 0);
    drive_field(10, 96, 0);
    check_eq("480i_two_diff_interlaced", o_interlaced, 1);
    check_eq("480i_early_mode", o_video_mode, 2);
    drive_field(11, 96, 48);
    drive_field(10, 96, 0);
    drive_field(11, 96, 48);
    check_eq("480i_mode", o_video_mode, 3);
    check_eq("480i_interlaced", o_interlaced, 1);
    check_eq("480i_doubler", o_line_doubler, 1);
    check_eq("480i_pulses", n_pulses, 5);
    check_eq("480i_v_total", o_v_total, 10);

    // Loss of vsync: about 5800 clocks still locked, about 6100 timed out.
    repeat (50) drive_line(96, -1);
    check_eq("los_before_mode", o_video_mode, 3);
    repeat (3) drive_line(96, -1);
    check_eq("los_mode", o_video_mode, 0);
    check_eq("los_valid", o_mode_valid, 0);
    check_eq("los_doubler", o_line_doubler, 0);
    check_eq("los_pulses", n_pulses, 6);
    repeat (10) drive_line(96, -1);
    check_eq("los_hold_pulses", n_pulses, 6);

    // Reset mid-field.
    drive_line(96, -1);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle("midreset");
    i_reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
